// File: rtl/dmem_pkg.sv
// Shared types and constants for the line-granular data-memory responder.
package dmem_pkg;

  localparam int unsigned LINE_W        = 256;
  localparam int unsigned LINE_OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Bits needed to hold LATENCY-1 in the latency counter.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return (latency < 3) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// DEPTH x LINE_W line storage: synchronous write port, combinational read port.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];

  // Contents survive reset on purpose; only the write port updates them.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_line_responder.sv
// Fixed-latency line read/write responder for the dcache memory side.
// Optional DMEM_RESP_PROTO_CHECK_EN adds a sticky proto_err_o and aborts on enable drop in WAIT.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef DMEM_RESP_PROTO_CHECK_EN
  ,
  output logic              proto_err_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(LATENCY);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic                proto_err_q, proto_err_d;
  logic                we_c;
  logic [LINE_W-1:0]   rdata_c;
  logic                unused_addr;

  // Only the line-index slice matters; offset and upper address bits are don't-care.
  assign unused_addr = ^addr_i;

  dmem_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (we_c),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata_c)
  );

  // ack_o is registered off the ACK state, so it is high during GAP; the
  // enable_i that lingers into that cycle is therefore ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;
    data_d      = data_q;
    proto_err_d = proto_err_q;
    we_c        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[LINE_OFFSET_W +: IDX_W];
          wr_d    = write_i;
          wdata_d = data_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
`ifdef DMEM_RESP_PROTO_CHECK_EN
        if (!enable_i) begin
          proto_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ACK;
        end
`else
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ACK;
`endif
      end
      ACK: begin
        ack_d   = 1'b1;
        we_c    = wr_q;
        if (!wr_q) data_d = rdata_c;
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      data_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;
`ifdef DMEM_RESP_PROTO_CHECK_EN
  assign proto_err_o = proto_err_q;
`else
  logic unused_proto;
  assign unused_proto = proto_err_q;
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed scoreboard bench for dmem_line_responder (LATENCY=10, DEPTH=512).
module tb_dmem_line_responder;

  localparam int unsigned LAT = 10;
  localparam int unsigned DEP = 512;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         enable_i = 1'b0;
  logic         write_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [255:0] data_i = '0;
  logic         ack_o;
  logic [255:0] data_o;
`ifdef DMEM_RESP_PROTO_CHECK_EN
  logic         proto_err_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [255:0] exp_q [$];
  logic [255:0] a5_line;

  dmem_line_responder #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
`ifdef DMEM_RESP_PROTO_CHECK_EN
    ,
    .proto_err_o (proto_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is accepted on the next rising edge.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                       output int t_acc);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = data;
    t_acc    = cyc + 1;
    if (!wr) exp_q.push_back(data);
  endtask

  // Bounded wait for ack; returns the edge count after which ack was seen, or -1.
  task automatic wait_ack(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (ack_o === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Waits for the ack of a request accepted at t_acc and scores it.
  task automatic complete(input string tag, input bit rd, input int t_acc);
    int at;
    logic [255:0] exp;
    wait_ack(3 * LAT, at);
    check({tag, "_ack_edge"}, 256'(at), 256'(t_acc + int'(LAT)));
    if (rd) begin
      if (exp_q.size() == 0) begin
        exp = '1;
        check({tag, "_sb_empty"}, 256'(0), 256'(1));
      end else begin
        exp = exp_q.pop_front();
      end
      check({tag, "_data"}, data_o, exp);
    end
  endtask

  initial begin
    int t0, t1, at;
    logic [255:0] rnd;
    logic [31:0]  raddr;

    a5_line = {32{8'hA5}};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ack", 256'(ack_o), 256'(0));
    check("rst_data", data_o, 256'(0));
    rst_i = 1'b1;
    @(negedge clk_i);

    // Preload line 3 through a write; a write must not disturb data_o
    issue(1'b1, 32'h60, a5_line, t0);
    complete("pre_wr", 1'b0, t0);
    check("wr_keeps_data", data_o, 256'(0));
    enable_i = 1'b0;
    @(negedge clk_i);
    check("ack_one_cycle", 256'(ack_o), 256'(0));
    @(negedge clk_i);

    // Read after reset
    issue(1'b0, 32'h60, a5_line, t0);
    complete("rd_line3", 1'b1, t0);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("rd_ack_pulse", 256'(ack_o), 256'(0));
    check("rd_data_hold", data_o, a5_line);
    @(negedge clk_i);

    // Write-back then read with enable held across the gap
    issue(1'b1, 32'h400, 256'h1234, t0);
    complete("wb_wr", 1'b0, t0);
    issue(1'b0, 32'h400, 256'h1234, t1);
    t1 = t0 + int'(LAT) + 2;
    complete("wb_rd", 1'b1, t1);
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Lingering enable one cycle past the ack must not start a second request
    issue(1'b0, 32'h60, a5_line, t0);
    complete("linger_rd", 1'b1, t0);
    @(negedge clk_i);
    enable_i = 1'b0;
    wait_ack(2 * LAT, at);
    check("linger_no_ack", 256'(at), 256'(-1));
    check("linger_data_hold", data_o, a5_line);

    // Index aliasing modulo DEPTH
    issue(1'b1, 32'h0000_0020, 256'hFF, t0);
    complete("alias_wr", 1'b0, t0);
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    issue(1'b0, 32'h0000_4020, 256'hFF, t0);
    complete("alias_rd", 1'b1, t0);
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset in WAIT discards the pending write
    issue(1'b1, 32'hE0, 256'hAA, t0);
    complete("l7_wr", 1'b0, t0);
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    issue(1'b1, 32'hE0, 256'hBB, t0);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    enable_i = 1'b0;
    #1;
    check("midrst_ack", 256'(ack_o), 256'(0));
    check("midrst_data", data_o, 256'(0));
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    wait_ack(2 * LAT, at);
    check("midrst_no_ack", 256'(at), 256'(-1));
    issue(1'b0, 32'hE0, 256'hAA, t0);
    complete("l7_rd", 1'b1, t0);
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);

`ifdef DMEM_RESP_PROTO_CHECK_EN
    // Enable drop in WAIT aborts and sets the sticky error
    check("proto_clear", 256'(proto_err_o), 256'(0));
    issue(1'b1, 32'hE0, 256'hCC, t0);
    repeat (3) @(negedge clk_i);
    enable_i = 1'b0;
    wait_ack(2 * LAT, at);
    check("proto_no_ack", 256'(at), 256'(-1));
    check("proto_set", 256'(proto_err_o), 256'(1));
    issue(1'b0, 32'hE0, 256'hAA, t0);
    complete("proto_next", 1'b1, t0);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("proto_sticky", 256'(proto_err_o), 256'(1));
    @(negedge clk_i);
`else
    // Without the check, an enable drop after accept still completes the write
    issue(1'b1, 32'hE0, 256'hCC, t0);
    repeat (3) @(negedge clk_i);
    enable_i = 1'b0;
    complete("drop_wr", 1'b0, t0);
    repeat (2) @(negedge clk_i);
    issue(1'b0, 32'hE0, 256'hCC, t0);
    complete("drop_rd", 1'b1, t0);
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
`endif

    // A few random write/read pairs on distinct lines
    for (int i = 0; i < 4; i++) begin
      rnd   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      raddr = {$urandom} & 32'hFFFF_FFE0;
      raddr[13:5] = 9'(20 + i);
      issue(1'b1, raddr, rnd, t0);
      complete("rnd_wr", 1'b0, t0);
      issue(1'b0, raddr ^ 32'hFFFF_C01F, rnd, t1);
      t1 = t0 + int'(LAT) + 2;
      complete("rnd_rd", 1'b1, t1);
      enable_i = 1'b0;
      repeat (2) @(negedge clk_i);
    end

    check("sb_drained", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
